keyseq_driver: RTL and testbench
================================

# keyseq_driver

Time-varying key driver for the Cute-Lock protected ITC99 benchmarks, including the 4-key, 3-bit b10 variant. It stores one key word per lock-counter phase, loaded serially over a valid/ready port. On `start` it replays the words on `keyinput` in lockstep with the locked core's free-running 2-bit phase counter. It sits between the key-provisioning path and the `keyinput*` pins of an encrypted core.

## Interface
- `KEY_BITS`, 3, width of one key word (matches `keyinput0..keyinput2`)
- `NUM_KEYS`, 4, key words per schedule period; power of two, 2..16
- `clock`  in  1  rising-edge clock, shared with the locked core
- `reset_n`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  key word offered on `load_data`
- `load_data`  in  KEY_BITS  key word for the next phase index
- `load_ready`  out  1  driver accepts a word this cycle
- `start`  in  1  single-cycle pulse; begin replay at phase 0 on the next cycle
- `stop`  in  1  single-cycle pulse; end replay
- `keyinput`  out  KEY_BITS  key word for the current phase; bit i drives `keyinputi`
- `phase`  out  log2(NUM_KEYS)  mirror of the core's phase counter
- `key_active`  out  1  high while `keyinput` carries the schedule
- `armed`  out  1  all NUM_KEYS words loaded, replay not running

## Operation
- Reset is asynchronous and active-low. All storage is cleared asynchronously.
- Reset values: `keyinput`=0, `phase`=0, `key_active`=0, `armed`=0, `load_ready`=1. FSM=EMPTY. Key memory=0. Write index=0.
- FSM states: EMPTY, LOAD, ARMED, RUN.
- EMPTY:
  - `load_ready`=1.
  - A handshake (`load_valid`&&`load_ready`) writes `mem[0]`, sets the write index to 1 and moves to LOAD.
  - If NUM_KEYS==1, the first handshake goes directly to ARMED.
- LOAD:
  - `load_ready`=1.
  - Each handshake writes `mem[wr_idx]` and increments `wr_idx`.
  - The handshake that writes index NUM_KEYS-1 moves to ARMED and resets `wr_idx` to 0.
- ARMED:
  - `load_ready`=0 and `armed`=1.
  - `start` moves to RUN.
  - A `load_valid` asserted while not ready is ignored; no data is lost because there is no handshake.
- RUN:
  - `load_ready`=0 and `key_active`=1.
  - `phase` increments by 1 each cycle, modulo NUM_KEYS, matching the core's Q counter sequence 0,1,2,3,0,…
  - `keyinput` = `mem[phase]` every cycle, registered.
- `stop` in RUN:
  - Without the zeroize macro, moves to ARMED and keeps the memory.
  - Forces `phase`=0 and `keyinput`=0.
- `start` outside ARMED is ignored. `stop` outside RUN is ignored.
- If `start` and `stop` arrive in the same cycle, `stop` wins: in ARMED the FSM stays ARMED; in RUN it applies the `stop` rules.
- Reloading is only possible from EMPTY. Reaching EMPTY requires reset, or `stop` with zeroize enabled.
- An assertion of `reset_n` mid-RUN drops `keyinput` to 0 and `key_active` to 0 immediately, without waiting for a clock edge.

## Timing
- Load throughput: 1 word per cycle. NUM_KEYS back-to-back handshakes reach ARMED at the edge of the last handshake.
- `start` sampled at edge t: from edge t onward, `key_active`=1, `phase`=0 and `keyinput`=`mem[0]`.
- At edge t+k: `phase`=k mod NUM_KEYS and `keyinput`=`mem[k mod NUM_KEYS]`.
- The core's counter must have been reset to phase 0 at the same edge t; the integration layer guarantees this.
- `stop` sampled at edge t: from edge t onward, `key_active`=0, `keyinput`=0, `phase`=0.
- `armed` and `load_ready` are registered from FSM state; there is no combinational path from inputs to outputs.

## Configuration
- `KEYSEQ_ZEROIZE_EN` defined:
  - `stop` in RUN clears every `mem` entry to 0, clears `wr_idx` and moves to EMPTY.
  - `load_ready` returns to 1 on the cycle after `stop`.
- `KEYSEQ_ZEROIZE_EN` undefined:
  - `stop` moves to ARMED and keys are retained.
  - A later `start` replays the same schedule without reloading.

## Test plan
- Reset then load: load 3'b010, 3'b101, 3'b110, 3'b011, then pulse `start`.
  - `keyinput` must read 010, 101, 110, 011, 010, … on consecutive cycles.
  - `phase` must read 0, 1, 2, 3, 0.
- Gaps in loading: drop `load_valid` between words.
  - `load_ready` stays 1.
  - `armed` asserts only after the 4th handshake.
  - A `load_valid` pulse in ARMED leaves the memory unchanged.
- Early `start`: pulse `start` in EMPTY and again after 2 words.
  - No transition; `key_active` stays 0.
  - The load completes normally afterwards.
- Simultaneous pulses:
  - `start`+`stop` in ARMED: the FSM stays ARMED.
  - `stop` after 6 RUN cycles: `keyinput`=0 and `phase`=0 on the next cycle.
  - Without zeroize, a re-`start` replays from `mem[0]`=010.
  - With zeroize, `load_ready`=1 and a re-`start` is ignored.
- Reset mid-RUN: assert `reset_n`=0 between clock edges during RUN.
  - `keyinput`=0 and `key_active`=0 immediately, `load_ready`=1 after release.
  - After release the memory reads back all zeros.
- Parameter variant: NUM_KEYS=2, KEY_BITS=5. Load 5'h1F, 5'h0A.
  - The output alternates 1F, 0A.
  - `phase` is 1 bit and toggles each cycle.

Source files
------------

// File: rtl/keyseq_driver.sv
// rtl/keyseq_driver.sv - replays a serially loaded key schedule in lockstep with a locked core's phase counter
// Optional feature: define KEYSEQ_ZEROIZE_EN to wipe the key memory and return to EMPTY on stop.
module keyseq_driver #(
  parameter  int KEY_BITS = 3,
  parameter  int NUM_KEYS = 4,
  localparam int PHASE_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load_valid,
  input  logic [KEY_BITS-1:0] load_data,
  output logic                load_ready,
  input  logic                start,
  input  logic                stop,
  output logic [KEY_BITS-1:0] keyinput,
  output logic [PHASE_W-1:0]  phase,
  output logic                key_active,
  output logic                armed
);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_ARMED, S_RUN} state_t;

  localparam logic [PHASE_W-1:0] LAST_IDX = PHASE_W'(NUM_KEYS - 1);

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] mem [NUM_KEYS];
  logic [PHASE_W-1:0]  wr_idx_q, wr_idx_d;
  logic [PHASE_W-1:0]  phase_d;
  logic [KEY_BITS-1:0] key_d;
  logic                wr_en;
  logic                zeroize;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_EMPTY;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    wr_en    = 1'b0;
    zeroize  = 1'b0;
    case (state_q)
      S_EMPTY, S_LOAD: begin
        if (load_valid && load_ready) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = S_ARMED;
            wr_idx_d = '0;
          end else begin
            state_d  = S_LOAD;
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_ARMED: begin
        // stop wins over a simultaneous start
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
`ifdef KEYSEQ_ZEROIZE_EN
          state_d  = S_EMPTY;
          wr_idx_d = '0;
          zeroize  = 1'b1;
`else
          state_d  = S_ARMED;
`endif
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Phase restarts at 0 on entry to RUN so it lines up with the core's counter reset
    phase_d = '0;
    key_d   = '0;
    if (state_d == S_RUN) begin
      if (state_q == S_RUN && NUM_KEYS > 1) phase_d = phase + 1'b1;
      key_d = mem[phase_d];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx_q] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      keyinput   <= '0;
      phase      <= '0;
      key_active <= 1'b0;
      armed      <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      keyinput   <= key_d;
      phase      <= phase_d;
      key_active <= (state_d == S_RUN);
      armed      <= (state_d == S_ARMED);
      load_ready <= (state_d == S_EMPTY) || (state_d == S_LOAD);
    end
  end

endmodule

// File: tb/tb_keyseq_driver.sv
// tb/tb_keyseq_driver.sv - randomized bench for keyseq_driver against a schedule-level reference model
module tb_keyseq_driver;

  localparam int NK = 4;

  logic       clock;
  logic       reset_n;
  logic       load_valid;
  logic [2:0] load_data;
  logic       load_ready;
  logic       start;
  logic       stop;
  logic [2:0] keyinput;
  logic [1:0] phase;
  logic       key_active;
  logic       armed;

  logic       v_load_valid;
  logic [4:0] v_load_data;
  logic       v_load_ready;
  logic       v_start;
  logic       v_stop;
  logic [4:0] v_keyinput;
  logic [0:0] v_phase;
  logic       v_key_active;
  logic       v_armed;

  int errors = 0;
  int checks = 0;

  logic [2:0] m_mem [NK];
  int         n_loaded;
  bit         running;
  int         k;

  keyseq_driver #(.KEY_BITS(3), .NUM_KEYS(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .stop(stop),
    .keyinput(keyinput), .phase(phase), .key_active(key_active), .armed(armed)
  );

  keyseq_driver #(.KEY_BITS(5), .NUM_KEYS(2)) dut_v (
    .clock(clock), .reset_n(reset_n),
    .load_valid(v_load_valid), .load_data(v_load_data), .load_ready(v_load_ready),
    .start(v_start), .stop(v_stop),
    .keyinput(v_keyinput), .phase(v_phase), .key_active(v_key_active), .armed(v_armed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) m_mem[i] = 3'd0;
    n_loaded = 0;
    running  = 1'b0;
    k        = 0;
  endtask

  // One clock of the schedule: count loaded words, then replay word k mod NK while running
  task automatic model_step(input bit lv, input logic [2:0] ld, input bit st, input bit sp);
    if (running) begin
      if (sp) begin
        running = 1'b0;
        k = 0;
`ifdef KEYSEQ_ZEROIZE_EN
        for (int i = 0; i < NK; i++) m_mem[i] = 3'd0;
        n_loaded = 0;
`endif
      end else begin
        k++;
      end
    end else if (n_loaded == NK) begin
      if (st && !sp) begin
        running = 1'b1;
        k = 0;
      end
    end else if (lv) begin
      m_mem[n_loaded] = ld;
      n_loaded++;
    end
  endtask

  task automatic check_outputs();
    check("keyinput",   32'(keyinput),   running ? 32'(m_mem[k % NK]) : 32'd0);
    check("phase",      32'(phase),      running ? 32'(k % NK) : 32'd0);
    check("key_active", 32'(key_active), 32'(running));
    check("armed",      32'(armed),      32'(!running && n_loaded == NK));
    check("load_ready", 32'(load_ready), 32'(n_loaded < NK));
  endtask

  task automatic tick(input bit lv, input logic [2:0] ld, input bit st, input bit sp);
    load_valid = lv;
    load_data  = ld;
    start      = st;
    stop       = sp;
    @(posedge clock);
    model_step(lv, ld, st, sp);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    load_valid = 1'b0; load_data = '0; start = 1'b0; stop = 1'b0;
    v_load_valid = 1'b0; v_load_data = '0; v_start = 1'b0; v_stop = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    check("v_load_ready_rst", 32'(v_load_ready), 32'd1);
    reset_n = 1'b1;

    // directed: early starts, gapped load, ignored load in ARMED, start+stop, run, stop, restart
    tick(0, 3'b000, 1, 0);
    tick(1, 3'b010, 0, 0);
    tick(0, 3'b000, 0, 0);
    tick(1, 3'b101, 0, 0);
    tick(0, 3'b000, 1, 0);
    tick(1, 3'b110, 0, 0);
    tick(0, 3'b000, 0, 0);
    tick(1, 3'b011, 0, 0);
    tick(1, 3'b111, 0, 0);
    tick(0, 3'b000, 1, 1);
    tick(0, 3'b000, 1, 0);
    repeat (5) tick(0, 3'b000, 0, 0);
    tick(0, 3'b000, 0, 1);
    tick(0, 3'b000, 1, 0);
    repeat (5) tick(0, 3'b000, 0, 0);

    // randomized epochs
    for (int e = 0; e < 4; e++) begin
      reset_pulse();
      for (int c = 0; c < 100; c++)
        tick(1'($urandom_range(0, 1)), 3'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, 9) == 0);
    end

    // asynchronous reset in the middle of a run
    reset_pulse();
    for (int i = 0; i < NK; i++) tick(1, 3'($urandom) | 3'b001, 0, 0);
    tick(0, 3'b000, 1, 0);
    repeat (3) tick(0, 3'b000, 0, 0);
    @(posedge clock);
    model_step(0, 3'b000, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_keyinput",   32'(keyinput),   32'd0);
    check("async_key_active", 32'(key_active), 32'd0);
    for (int i = 0; i < NK; i++) check("async_mem_clear", 32'(dut.mem[i]), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tick(0, 3'b000, 0, 0);

    // NUM_KEYS=2, KEY_BITS=5 variant
    v_load_valid = 1'b1; v_load_data = 5'h1F;
    @(posedge clock); @(negedge clock);
    check("v_ready_mid", 32'(v_load_ready), 32'd1);
    check("v_armed_mid", 32'(v_armed), 32'd0);
    v_load_data = 5'h0A;
    @(posedge clock); @(negedge clock);
    v_load_valid = 1'b0;
    check("v_armed", 32'(v_armed), 32'd1);
    check("v_ready", 32'(v_load_ready), 32'd0);
    v_start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); @(negedge clock);
      v_start = 1'b0;
      check("v_keyinput", 32'(v_keyinput), (c % 2 == 0) ? 32'h1F : 32'h0A);
      check("v_phase", 32'(v_phase), 32'(c % 2));
      check("v_key_active", 32'(v_key_active), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
